// File: rtl/bcd_auto_counter_pkg.sv
// Shared constants and helpers for the two-digit BCD counter and its decade digits.
// Holds the digit maximum and the active-low digit-enable encodings.
package bcd_auto_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       DIGIT_MAX = 4'd9;

    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;
    localparam logic [1:0] AN_OFF    = 2'b11;

    // Out-of-range nibbles become 0 so the counter never holds a non-BCD value.
    function automatic bcd_t clamp_bcd(input logic [3:0] nib);
        return (nib > DIGIT_MAX) ? 4'd0 : nib;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade (0..9) up/down counter with synchronous load.
// carry_out/borrow_out flag the step that wraps this digit, for chaining.
module bcd_digit
    import bcd_auto_counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    input  logic up,
    input  logic load,
    input  bcd_t load_nib,
    output bcd_t digit,
    output logic carry_out,
    output logic borrow_out
);

    assign carry_out  = step &&  up && (digit == DIGIT_MAX);
    assign borrow_out = step && !up && (digit == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= clamp_bcd(load_nib);
        end else if (step) begin
            if (up) begin
                digit <= (digit == DIGIT_MAX) ? 4'd0 : digit + 4'd1;
            end else begin
                digit <= (digit == 4'd0) ? DIGIT_MAX : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_auto_counter.sv
// Two-digit BCD counter with prescaler, up/down, pause and load, plus a
// two-slot display multiplexer feeding a BCD-to-7-segment decoder.
module bcd_auto_counter #(
    parameter int PRESCALE = 50_000_000,
    parameter int MUX_DIV  = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       W,
    output logic       X,
    output logic       Y,
    output logic       Z,
    output logic [1:0] an,
    output logic       tc
);
    import bcd_auto_counter_pkg::*;

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SLOT_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MUX_DIV - 1);

    logic [PRE_W-1:0]  pre;
    logic [SLOT_W-1:0] slot;
    logic              sel;
    logic              step;
    bcd_t              units;
    bcd_t              tens;
    logic              units_carry;
    logic              units_borrow;
    logic              tens_carry;
    logic              tens_borrow;

    assign step = en && (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (load) begin
            pre <= '0;
        end else if (en) begin
            pre <= step ? '0 : pre + PRE_W'(1);
        end
    end

    bcd_digit u_units (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step),
        .up         (up),
        .load       (load),
        .load_nib   (load_val[3:0]),
        .digit      (units),
        .carry_out  (units_carry),
        .borrow_out (units_borrow)
    );

    bcd_digit u_tens (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (units_carry | units_borrow),
        .up         (up),
        .load       (load),
        .load_nib   (load_val[7:4]),
        .digit      (tens),
        .carry_out  (tens_carry),
        .borrow_out (tens_borrow)
    );

    // A wrap of the tens digit is a 99->00 or 00->99 wrap of the whole count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc <= 1'b0;
        end else begin
            tc <= (tens_carry | tens_borrow) && !load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
            sel  <= 1'b0;
        end else if (slot == SLOT_LAST) begin
            slot <= '0;
            sel  <= !sel;
        end else begin
            slot <= slot + SLOT_W'(1);
        end
    end

    assign count = {tens, units};

    always_comb begin
        {W, X, Y, Z} = units;
        an           = AN_UNITS;
        if (sel) begin
            {W, X, Y, Z} = tens;
            an           = AN_TENS;
        end
    end

endmodule

// File: tb/tb_bcd_auto_counter.sv
// Bench for bcd_auto_counter: directed vector table, corner sequences and
// randomized traffic checked against an arithmetic model of the counter.
module tb_bcd_auto_counter;

    localparam int PRESCALE = 4;
    localparam int MUX_DIV  = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       W, X, Y, Z;
    logic [1:0] an;
    logic       tc;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: count as a plain integer 0..99.
    int m_cnt;
    int m_pre;
    int m_slot;
    bit m_sel;
    bit m_tc;

    typedef struct {
        logic       en;
        logic       up;
        logic       load;
        logic [7:0] lv;
        logic [7:0] exp_count;
        logic       exp_tc;
    } vec_t;

    vec_t vtab[$];

    bcd_auto_counter #(
        .PRESCALE (PRESCALE),
        .MUX_DIV  (MUX_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .W        (W),
        .X        (X),
        .Y        (Y),
        .Z        (Z),
        .an       (an),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_pre  = 0;
        m_slot = 0;
        m_sel  = 1'b0;
        m_tc   = 1'b0;
    endtask

    task automatic model_edge();
        int tn, un;
        if (!rst_n) return;
        m_tc = 1'b0;
        if (load) begin
            tn    = (int'(load_val[7:4]) > 9) ? 0 : int'(load_val[7:4]);
            un    = (int'(load_val[3:0]) > 9) ? 0 : int'(load_val[3:0]);
            m_cnt = tn * 10 + un;
            m_pre = 0;
        end else if (en) begin
            if (m_pre == PRESCALE - 1) begin
                m_pre = 0;
                if (up) begin
                    m_tc  = (m_cnt == 99);
                    m_cnt = (m_cnt + 1) % 100;
                end else begin
                    m_tc  = (m_cnt == 0);
                    m_cnt = (m_cnt + 99) % 100;
                end
            end else begin
                m_pre++;
            end
        end
        if (m_slot == MUX_DIV - 1) begin
            m_slot = 0;
            m_sel  = !m_sel;
        end else begin
            m_slot++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] et, eu, ed;
        et = 4'(m_cnt / 10);
        eu = 4'(m_cnt % 10);
        ed = m_sel ? et : eu;
        chk({tag, "_count"}, count, {et, eu});
        chk({tag, "_wxyz"}, {4'd0, W, X, Y, Z}, {4'd0, ed});
        chk({tag, "_an"}, {6'd0, an}, {6'd0, (m_sel ? 2'b01 : 2'b10)});
        chk({tag, "_tc"}, {7'd0, tc}, {7'd0, m_tc});
    endtask

    // Inputs are changed 2 time units after an edge; outputs checked there too.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic set_in(input logic e, input logic u, input logic l, input logic [7:0] v);
        en       = e;
        up       = u;
        load     = l;
        load_val = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic e, input logic u, input logic l,
                                input logic [7:0] v, input logic [7:0] ec, input logic et);
        vec_t r;
        r.en = e; r.up = u; r.load = l; r.lv = v; r.exp_count = ec; r.exp_tc = et;
        vtab.push_back(r);
    endfunction

    logic [5:0] samp[8];

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        model_reset();
        #1;
        chk("reset_count", count, 8'h00);
        chk("reset_an", {6'd0, an}, 8'h02);
        chk("reset_wxyz", {4'd0, W, X, Y, Z}, 8'h00);
        chk("reset_tc", {7'd0, tc}, 8'h00);
        do_reset();

        // Up wrap, down borrow, down wrap, clamp and load-over-step.
        add(1, 1, 1, 8'h98, 8'h98, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 8'h00, 8'h98, 0);
        add(1, 1, 0, 8'h00, 8'h99, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 8'h00, 8'h99, 0);
        add(1, 1, 0, 8'h00, 8'h00, 1);
        add(1, 1, 0, 8'h00, 8'h00, 0);
        add(1, 0, 1, 8'h10, 8'h10, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 8'h00, 8'h10, 0);
        add(1, 0, 0, 8'h00, 8'h09, 0);
        add(1, 0, 1, 8'h00, 8'h00, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 8'h00, 8'h00, 0);
        add(1, 0, 0, 8'h00, 8'h99, 1);
        add(1, 0, 0, 8'h00, 8'h99, 0);
        add(1, 1, 1, 8'hA5, 8'h05, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 8'h00, 8'h05, 0);
        add(1, 1, 1, 8'h42, 8'h42, 0);
        add(1, 1, 0, 8'h00, 8'h42, 0);
        add(0, 1, 1, 8'hF9, 8'h09, 0);
        add(0, 1, 0, 8'h00, 8'h09, 0);

        foreach (vtab[i]) begin
            set_in(vtab[i].en, vtab[i].up, vtab[i].load, vtab[i].lv);
            tick();
            chk($sformatf("vec%0d_count", i), count, vtab[i].exp_count);
            chk($sformatf("vec%0d_tc", i), {7'd0, tc}, {7'd0, vtab[i].exp_tc});
        end
        set_in(1'b0, 1'b1, 1'b0, 8'h00);

        // Asynchronous reset mid-count at 37, then first step PRESCALE cycles after release.
        set_in(1'b0, 1'b1, 1'b1, 8'h37);
        tick();
        chk("pre_reset_count", count, 8'h37);
        set_in(1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_count", count, 8'h00);
        chk("async_rst_an", {6'd0, an}, 8'h02);
        chk("async_rst_wxyz", {4'd0, W, X, Y, Z}, 8'h00);
        chk("async_rst_tc", {7'd0, tc}, 8'h00);
        tick();
        check_model("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_hold", count, 8'h00);
        end
        tick();
        chk("post_rst_first_step", count, 8'h01);

        // Pause freezes the prescaler mid-period.
        set_in(1'b0, 1'b1, 1'b1, 8'h20);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("pause_hold", count, 8'h20);
        en = 1'b1;
        tick();
        chk("resume_1", count, 8'h20);
        tick();
        chk("resume_2", count, 8'h21);

        // Display multiplexing with the count frozen at 47.
        set_in(1'b0, 1'b1, 1'b1, 8'h47);
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_model($sformatf("mux%0d", i));
            samp[i] = {W, X, Y, Z, an};
            chk("mux_combo", {7'd0, (samp[i] == 6'b0111_10) || (samp[i] == 6'b0100_01)}, 8'h01);
        end
        for (int i = 0; i < 4; i++) chk("mux_period", {2'd0, samp[i]}, {2'd0, samp[i+4]});
        for (int i = 0; i < 6; i++) chk("mux_alt", {7'd0, samp[i] != samp[i+2]}, 8'h01);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0), 8'($urandom));
            tick();
            check_model("rand");
        end
        set_in(1'b0, 1'b1, 1'b1, 8'h90);
        tick();
        for (int i = 0; i < 200; i++) begin
            set_in(1'b1, (i < 100), 1'b0, 8'h00);
            tick();
            check_model("sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
